// File: rtl/pattern_fill.sv
// pattern_fill: fills a BRAM with an arithmetic sequence (seed, seed+step, ...)
// on a start command from the PS, then reports done until start drops.
// Optional feature: define PATFILL_SUM_EN to reserve word 0 for a 32-bit
// checksum of all filled values, written in one extra SUM cycle.
module pattern_fill #(
  parameter int unsigned LAST_ADDR = 8188
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ps_control,
  output logic [31:0] pl_status,
  output logic [12:0] bram_addr,
  input  logic [31:0] bram_rddata,
  output logic [31:0] bram_wrdata,
  output logic [3:0]  bram_we
);

  localparam logic [12:0] LastAddr = 13'(LAST_ADDR);
`ifdef PATFILL_SUM_EN
  // Word 0 is reserved for the checksum, so the fill starts at word 1.
  localparam logic [12:0] FirstAddr = 13'd4;
`else
  localparam logic [12:0] FirstAddr = 13'd0;
`endif

  localparam logic [31:0] StatusIdle = 32'd0;
  localparam logic [31:0] StatusDone = 32'd1;
  localparam logic [31:0] StatusBusy = 32'd2;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StSum,
    StDone
  } state_e;

  state_e      state;
  logic [31:0] val;
  logic [31:0] stp;
`ifdef PATFILL_SUM_EN
  logic [31:0] sum;
`endif

  logic start;
  assign start = ps_control[0];

  // Read data and the reserved command bits have no function in this block.
  logic unused_inputs;
  assign unused_inputs = ^{bram_rddata, ps_control[7:1]};

  // Control FSM; every output is registered and updated on the transition
  // into the state that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      bram_addr   <= 13'd0;
      bram_we     <= 4'h0;
      bram_wrdata <= 32'd0;
      pl_status   <= StatusIdle;
      val         <= 32'd0;
      stp         <= 32'd0;
`ifdef PATFILL_SUM_EN
      sum         <= 32'd0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          bram_we <= 4'h0;
          if (start) begin
            state       <= StFill;
            val         <= {16'd0, ps_control[31:16]};
            stp         <= {24'd0, ps_control[15:8]};
            bram_addr   <= FirstAddr;
            bram_we     <= 4'hf;
            bram_wrdata <= {16'd0, ps_control[31:16]};
            pl_status   <= StatusBusy;
`ifdef PATFILL_SUM_EN
            sum         <= 32'd0;
`endif
          end
        end

        StFill: begin
          if (bram_addr == LastAddr) begin
`ifdef PATFILL_SUM_EN
            state       <= StSum;
            sum         <= sum + val;
            bram_addr   <= 13'd0;
            bram_we     <= 4'hf;
            bram_wrdata <= sum + val;
`else
            state       <= StDone;
            bram_we     <= 4'h0;
            pl_status   <= StatusDone;
`endif
          end else begin
            val         <= val + stp;
            bram_addr   <= bram_addr + 13'd4;
            bram_wrdata <= val + stp;
`ifdef PATFILL_SUM_EN
            sum         <= sum + val;
`endif
          end
        end

        StSum: begin
          state     <= StDone;
          bram_we   <= 4'h0;
          pl_status <= StatusDone;
        end

        StDone: begin
          bram_we <= 4'h0;
          // Start must drop before another run can be launched.
          if (!start) begin
            state     <= StIdle;
            pl_status <= StatusIdle;
          end
        end

        default: begin
          state     <= StIdle;
          bram_we   <= 4'h0;
          pl_status <= StatusIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_fill.sv
// Scoreboard bench for pattern_fill: the driver pushes every expected BRAM
// write of a run into a queue, the monitor pops and compares on each write.
module tb_pattern_fill;

  localparam int unsigned LastAddr = 8188;
  localparam int          NWords   = LastAddr / 4 + 1;
  localparam int          Latency  = 2049;
  localparam logic [31:0] Sentinel = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic [31:0] ps_control;
  logic [31:0] pl_status;
  logic [12:0] bram_addr;
  logic [31:0] bram_rddata;
  logic [31:0] bram_wrdata;
  logic [3:0]  bram_we;

  pattern_fill #(
    .LAST_ADDR(LastAddr)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps_control (ps_control),
    .pl_status  (pl_status),
    .bram_addr  (bram_addr),
    .bram_rddata(bram_rddata),
    .bram_wrdata(bram_wrdata),
    .bram_we    (bram_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem[NWords];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: the whole run's writes from the arithmetic-sequence rule.
  task automatic push_run(input logic [31:0] ctrl);
    logic [31:0] seed;
    logic [31:0] step;
    logic [31:0] v;
    logic [31:0] total;
    seed  = {16'd0, ctrl[31:16]};
    step  = {24'd0, ctrl[15:8]};
    total = 32'd0;
`ifdef PATFILL_SUM_EN
    for (int k = 1; k < NWords; k++) begin
      v = seed + step * 32'(k - 1);
      total += v;
      exp_q.push_back('{addr: 13'(4 * k), data: v});
    end
    exp_q.push_back('{addr: 13'd0, data: total});
`else
    for (int k = 0; k < NWords; k++) begin
      v = seed + step * 32'(k);
      exp_q.push_back('{addr: 13'(4 * k), data: v});
    end
`endif
  endtask

  // Monitor: every observed write must be the next one the model predicted.
  always @(negedge clk) begin
    if (mon_en && bram_we !== 4'h0) begin
      wr_t e;
      check("write enable", 32'(bram_we), 32'hf);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected write: addr %h data %h, none expected", bram_addr,
                 bram_wrdata);
      end else begin
        e = exp_q.pop_front();
        check("write addr", 32'(bram_addr), 32'(e.addr));
        check("write data", bram_wrdata, e.data);
      end
      mem[int'(bram_addr[12:2])] = bram_wrdata;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < NWords; i++) mem[i] = Sentinel;
  endtask

  // One full run; drop_at>0 replaces the command mid-fill with start low and
  // different seed/step; hold keeps start high through DONE for a while.
  task automatic run(input logic [31:0] ctrl, input bit hold, input int drop_at);
    int n;
    bit seen;
    @(negedge clk);
    push_run(ctrl);
    ps_control = ctrl;
    seen = 1'b0;
    for (n = 1; n <= Latency + 50; n++) begin
      @(negedge clk);
      if (n == drop_at) ps_control = 32'hFFFF_FF00;
      if (pl_status[0] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      check("busy status", pl_status, 32'h2);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done timeout: got no done, expected done after %0d cycles", Latency);
    end else begin
      check("start-to-done latency", 32'(n), 32'(Latency));
      check("done status", pl_status, 32'h1);
    end
    if (hold) begin
      repeat (5) begin
        @(negedge clk);
        check("done held", pl_status, 32'h1);
      end
      ps_control = 32'd0;
    end else if (drop_at == 0) begin
      ps_control = 32'd0;
    end
    @(negedge clk);
    check("back to idle", pl_status, 32'h0);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("idle status", pl_status, 32'h0);
    end
    exp_q.delete();
  endtask

  task automatic reset_abort(input logic [31:0] ctrl);
    @(negedge clk);
    push_run(ctrl);
    ps_control = ctrl;
    repeat (100) @(negedge clk);
    reset      = 1'b1;
    ps_control = 32'd0;
    @(negedge clk);
    exp_q.delete();
    check("abort we", 32'(bram_we), 32'h0);
    check("abort status", pl_status, 32'h0);
    check("abort addr", 32'(bram_addr), 32'h0);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("post-abort status", pl_status, 32'h0);
    end
    check("word 50 written", mem[50], 32'(ctrl[31:16]) + 32'(ctrl[15:8]) *
`ifdef PATFILL_SUM_EN
          32'd49);
`else
          32'd50);
`endif
    check("word 150 untouched", mem[150], Sentinel);
    check("last word untouched", mem[NWords - 1], Sentinel);
  endtask

  initial begin
    int bad;
    logic [31:0] ctrl;
    reset       = 1'b1;
    ps_control  = 32'd0;
    bram_rddata = 32'h1234_5678;
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset status", pl_status, 32'h0);
    check("reset we", 32'(bram_we), 32'h0);
    check("reset addr", 32'(bram_addr), 32'h0);
    check("reset wrdata", bram_wrdata, 32'h0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle after reset", pl_status, 32'h0);

    // Reference run
    run(32'h0005_0301, 1'b0, 0);
`ifdef PATFILL_SUM_EN
    check("word1", mem[1], 32'd5);
    check("word2047", mem[2047], 32'd6143);
    check("word0 checksum", mem[0], 32'h0060_03FE);
`else
    check("word0", mem[0], 32'd5);
    check("word1", mem[1], 32'd8);
    check("word2047", mem[2047], 32'd6146);
`endif

    // Step 0: every filled word equals the seed
    clear_mem();
    run(32'h0007_0001, 1'b0, 0);
    bad = 0;
`ifdef PATFILL_SUM_EN
    for (int i = 1; i < NWords; i++) if (mem[i] !== 32'd7) bad++;
    check("step0 checksum", mem[0], 32'd7 * 32'(NWords - 1));
`else
    for (int i = 0; i < NWords; i++) if (mem[i] !== 32'd7) bad++;
`endif
    check("step0 words not equal seed", 32'(bad), 32'd0);

    // Start dropped mid-fill, then start held through DONE
    run(32'h0005_0301, 1'b0, 500);
    run(32'h0009_0401, 1'b1, 0);

    // Reset during fill
    clear_mem();
    reset_abort(32'h0003_0201);

    // Back-to-back runs: second must not inherit val/sum
    run(32'h0001_0101, 1'b0, 0);
    run(32'h0002_0201, 1'b0, 0);
`ifdef PATFILL_SUM_EN
    check("b2b word1", mem[1], 32'd2);
    check("b2b word2", mem[2], 32'd4);
`else
    check("b2b word0", mem[0], 32'd2);
    check("b2b word1", mem[1], 32'd4);
`endif

    // Random commands, reserved bits included
    for (int r = 0; r < 3; r++) begin
      ctrl = $urandom() | 32'h1;
      run(ctrl, 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_fill.md
PATTERN_FILL -- requirements
Module: pattern_fill

Interface
REQ-001 SHALL have parameter LAST_ADDR, default 8188, byte address of the final 32-bit BRAM word.
REQ-002 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port ps_control, input, 32, PS command: [0] start/ack, [15:8] step, [31:16] seed.
REQ-005 SHALL have port pl_status, output, 32, [0] done, [1] busy, [31:2] zero.
REQ-006 SHALL have port bram_addr, output, 13, BRAM byte address, always word-aligned ([1:0]=0).
REQ-007 SHALL have port bram_rddata, input, 32, BRAM read data; ignored by this block.
REQ-008 SHALL have port bram_wrdata, output, 32, BRAM write data.
REQ-009 SHALL have port bram_we, output, 4, byte write enables: 4'hf or 4'h0 only.

Function
REQ-010 SHALL implement FSM states IDLE, FILL, SUM, DONE; SUM is reachable only when PATFILL_SUM_EN is defined.
REQ-011 IDLE: SHALL hold bram_we=0; when ps_control[0]=1, SHALL capture seed (zero-extended to 32 bits) into val and step (zero-extended) into stp, load bram_addr with the first fill address, then go to FILL.
REQ-012 FILL: SHALL drive bram_we=4'hf and bram_wrdata=val every cycle; each cycle SHALL do val<=val+stp and bram_addr<=bram_addr+4.
REQ-013 FILL SHALL exit after the cycle in which bram_addr==LAST_ADDR is written; next state is SUM if enabled, otherwise DONE.
REQ-014 All arithmetic on val and sum SHALL be 32-bit, wrapping modulo 2^32.
REQ-015 DONE: SHALL drive bram_we=0 and pl_status[0]=1; SHALL go to IDLE when ps_control[0]=0, otherwise stay.
REQ-016 pl_status[1] SHALL be 1 exactly in FILL and SUM.
REQ-017 Changes to ps_control during FILL/SUM SHALL be ignored, including deassertion of bit 0; seed/step are sampled only at IDLE exit.
REQ-018 If ps_control[0] is already 0 on DONE entry, DONE SHALL last exactly one cycle.
REQ-019 Start held high through DONE SHALL NOT retrigger; a new run requires a 0 then a 1 on ps_control[0].
REQ-020 No BRAM write SHALL occur outside FILL and SUM.
REQ-021 stp=0 SHALL fill every written word with seed.

Reset
REQ-022 On reset=1 at a clk edge, state SHALL become IDLE; bram_addr=0, bram_we=0, bram_wrdata=0, pl_status=0, val=0, stp=0, sum=0.
REQ-023 Reset during FILL/SUM SHALL abort immediately; already-written words stay, no further writes, no done.

Configuration
REQ-024 Macro PATFILL_SUM_EN SHALL select the checksum feature.
REQ-025 Without PATFILL_SUM_EN: first fill address 0; word k (address 4k, k=0..2047) = seed+k*step; FILL lasts 2048 cycles.
REQ-026 With PATFILL_SUM_EN: first fill address 4; word k (k=1..2047) = seed+(k-1)*step; sum accumulates every FILL value; FILL lasts 2047 cycles.
REQ-027 With PATFILL_SUM_EN, SUM SHALL last one cycle: bram_addr=0, bram_we=4'hf, bram_wrdata=final sum, then go to DONE.
REQ-028 Start-to-done latency SHALL be 2049 cycles without PATFILL_SUM_EN and 2049 cycles with it, counted from the IDLE cycle sampling start to the first cycle with pl_status[0]=1.

Verification
REQ-029 Macro off, ps_control=0x0005_0301 -> word0=5, word1=8, word2047=6146; pl_status=1 after 2049 cycles; busy=1 during FILL.
REQ-030 Macro on, ps_control=0x0005_0301 -> word1=5, word2047=6143, word0=0x006003FE, one write to address 0.
REQ-031 ps_control=0x0007_0001 (step 0) -> all filled words = 7.
REQ-032 Start dropped mid-FILL -> fill completes, DONE lasts 1 cycle, return to IDLE; start held high -> DONE held until ps_control=0, no second run.
REQ-033 Reset asserted at FILL cycle 100 -> bram_we=0 on the next cycle, pl_status=0, state IDLE, words 100+ untouched.
REQ-034 Back-to-back runs with ps_control=0x0001_0101 then 0x0002_0201 -> second fill uses seed 2, step 2; no stale val or sum.
